// File: rtl/noc_flit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : noc_flit_pkg                                                |
// | Purpose  : Shared NoC flit definitions. Provides the flag bit offsets   |
// |            (counted down from the flit MSB), the serializer state       |
// |            type and the helper that finds the next valid flit in a      |
// |            packed 3-flit word.                                          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package noc_flit_pkg;

   // Flag positions measured from the MSB of a flit: bit [F-1-offset].
   localparam int FLIT_VALID_BIT = 0;
   localparam int FLIT_HEAD_BIT  = 1;
   localparam int FLIT_TAIL_BIT  = 2;

   // SEND_n encodes the 1-based index of the flit being presented, so a
   // state value doubles as a flit index.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_1 = 2'd1,
      SEND_2 = 2'd2,
      SEND_3 = 2'd3
   } state_t;

   // valid_word[0] is the valid bit of flit 1, [2] of flit 3.
   // Returns the first flit index strictly after cur whose valid bit is
   // set, or IDLE when there is none. cur == IDLE searches from flit 1.
   function automatic state_t next_valid_index(input logic [2:0] valid_word,
                                               input state_t     cur);
      state_t idx;
      idx = IDLE;
      if ((cur == IDLE) && valid_word[0]) begin
         idx = SEND_1;
      end else if (((cur == IDLE) || (cur == SEND_1)) && valid_word[1]) begin
         idx = SEND_2;
      end else if ((cur != SEND_3) && valid_word[2]) begin
         idx = SEND_3;
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/flit_serializer_3_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : flit_serializer_3_if                                       |
// | Purpose   : Word-input handshake, flit output link and credit return   |
// |             of the 3-flit serializer.                                  |
// | Signals   : data_in/valid_in/ready_out - packed word handshake         |
// |             flit_out/valid_out         - flit link to the router       |
// |             credit_in                  - one-slot credit return pulse  |
// |             credits                    - current credit count (debug)  |
// |             pkt_count/stall_count      - only with                     |
// |                                          FLIT_SERIALIZER_STATS_EN      |
// | Modports  : master (upstream + router side), slave (serializer)        |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface flit_serializer_3_if #(
   parameter int WIDTH_IN     = 36,
   parameter int BUFFER_DEPTH = 8
);
   localparam int FLIT_WIDTH   = WIDTH_IN / 3;
   localparam int CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1);

   logic [WIDTH_IN-1:0]     data_in;
   logic                    valid_in;
   logic                    ready_out;
   logic [FLIT_WIDTH-1:0]   flit_out;
   logic                    valid_out;
   logic                    credit_in;
   logic [CREDIT_WIDTH-1:0] credits;
`ifdef FLIT_SERIALIZER_STATS_EN
   logic [31:0]             pkt_count;
   logic [31:0]             stall_count;

   modport master (
      output data_in, valid_in, credit_in,
      input  ready_out, flit_out, valid_out, credits, pkt_count, stall_count
   );
   modport slave (
      input  data_in, valid_in, credit_in,
      output ready_out, flit_out, valid_out, credits, pkt_count, stall_count
   );
`else
   modport master (
      output data_in, valid_in, credit_in,
      input  ready_out, flit_out, valid_out, credits
   );
   modport slave (
      input  data_in, valid_in, credit_in,
      output ready_out, flit_out, valid_out, credits
   );
`endif
endinterface
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : credit_counter                                              |
// | Purpose  : Up/down saturating credit counter, loaded with DEPTH on     |
// |            reset. inc and dec together leave the count unchanged.      |
// | Ports    : clk, rst  - clock, synchronous active-high reset            |
// |            inc_i     - credit returned                                 |
// |            dec_i     - credit consumed                                 |
// |            count_o   - current count                                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module credit_counter #(
   parameter int DEPTH = 8,
   parameter int WIDTH = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o
);
   localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != FULL)) begin
         count_d = count_q + WIDTH'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= FULL;
      end else begin
         count_q <= count_d;
      end
   end

   // A return with no matching consumption while full means the router
   // handed back a slot it never had; the count saturates.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(inc_i && !dec_i && (count_q == FULL)))
            else $error("credit_counter: credit returned while already full");
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/flit_serializer_3.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : flit_serializer_3                                           |
// | Purpose  : Accepts one packed 3-flit word per handshake and emits its  |
// |            valid flits one per cycle onto a credit-controlled NoC      |
// |            injection link. Invalid flits are skipped and the packet    |
// |            ends at its tail flit; flit contents are never altered.     |
// | Ports    : clk, rst - clock, synchronous active-high reset             |
// |            bus      - flit_serializer_3_if.slave (word handshake,      |
// |                       flit link, credit return, credit count)          |
// | Options  : FLIT_SERIALIZER_STATS_EN adds pkt_count / stall_count       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module flit_serializer_3
   import noc_flit_pkg::*;
#(
   parameter int WIDTH_IN         = 36,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int BUFFER_DEPTH     = 8
) (
   input  logic               clk,
   input  logic               rst,
   flit_serializer_3_if.slave bus
);
   localparam int FLIT_WIDTH   = WIDTH_IN / 3;
   localparam int CREDIT_WIDTH = $clog2(BUFFER_DEPTH + 1);

   // The word must split evenly and each flit must hold its flags plus VC.
   generate
      if (((WIDTH_IN % 3) != 0) || (FLIT_HEAD_BIT >= FLIT_WIDTH) ||
          (FLIT_TAIL_BIT + 1 + VC_ADDRESS_WIDTH > FLIT_WIDTH)) begin : g_bad_params
         $error("flit_serializer_3: WIDTH_IN/VC_ADDRESS_WIDTH combination unsupported");
      end
   endgenerate

   // Bit k of the result is the valid bit of flit k+1 (flit 1 in the MSBs).
   function automatic logic [2:0] valid_mask(input logic [WIDTH_IN-1:0] w);
      logic [2:0] m;
      m[0] = w[3*FLIT_WIDTH-1-FLIT_VALID_BIT];
      m[1] = w[2*FLIT_WIDTH-1-FLIT_VALID_BIT];
      m[2] = w[1*FLIT_WIDTH-1-FLIT_VALID_BIT];
      return m;
   endfunction

   state_t                  state_q, state_d;
   logic [WIDTH_IN-1:0]     hold_q, hold_d;
   logic [FLIT_WIDTH-1:0]   w_cur_flit;
   logic [CREDIT_WIDTH-1:0] w_credits;
   state_t                  w_next_idx;
   state_t                  w_first_idx;
   logic                    w_cur_tail;
   logic                    w_cur_last;
   logic                    w_xfer;
   logic                    w_ready;
   logic                    w_accept;

   always_comb begin
      w_cur_flit = '0;
      case (state_q)
         SEND_1:  w_cur_flit = hold_q[3*FLIT_WIDTH-1 -: FLIT_WIDTH];
         SEND_2:  w_cur_flit = hold_q[2*FLIT_WIDTH-1 -: FLIT_WIDTH];
         SEND_3:  w_cur_flit = hold_q[1*FLIT_WIDTH-1 -: FLIT_WIDTH];
         default: w_cur_flit = '0;
      endcase
   end

   assign w_next_idx  = next_valid_index(valid_mask(hold_q), state_q);
   assign w_first_idx = next_valid_index(valid_mask(bus.data_in), IDLE);
   assign w_cur_tail  = w_cur_flit[FLIT_WIDTH-1-FLIT_TAIL_BIT];
   // Anything after a tail flit is ignored, so a tail is always last.
   assign w_cur_last  = w_cur_tail || (w_next_idx == IDLE);

   // rst gating keeps the reset cycle silent even though state_q still
   // holds the interrupted packet until the edge.
   assign w_xfer   = !rst && (state_q != IDLE) && (w_credits != '0);
   // Accepting on the last transfer lets packets run back-to-back.
   assign w_ready  = !rst && ((state_q == IDLE) || (w_xfer && w_cur_last));
   assign w_accept = bus.valid_in && w_ready;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      if (w_xfer) begin
         state_d = w_cur_last ? IDLE : w_next_idx;
      end
      // A word with no valid flit yields IDLE here and is simply dropped.
      if (w_accept) begin
         hold_d  = bus.data_in;
         state_d = w_first_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   credit_counter #(
      .DEPTH (BUFFER_DEPTH),
      .WIDTH (CREDIT_WIDTH)
   ) u_credit_counter (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (bus.credit_in),
      .dec_i   (w_xfer),
      .count_o (w_credits)
   );

   assign bus.flit_out  = w_cur_flit;
   assign bus.valid_out = w_xfer;
   assign bus.ready_out = w_ready;
   assign bus.credits   = w_credits;

`ifdef FLIT_SERIALIZER_STATS_EN
   logic [31:0] pkt_count_q;
   logic [31:0] stall_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count_q   <= '0;
         stall_count_q <= '0;
      end else begin
         if (w_xfer && w_cur_tail) begin
            pkt_count_q <= pkt_count_q + 32'd1;
         end
         if ((state_q != IDLE) && (w_credits == '0)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign bus.pkt_count   = pkt_count_q;
   assign bus.stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flit_serializer_3.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_flit_serializer_3                                        |
// | Purpose  : Self-checking bench for flit_serializer_3. Two instances:   |
// |            dut0 with BUFFER_DEPTH=8, dut1 with BUFFER_DEPTH=2. Each     |
// |            is tracked by a packet-level model: a queue of flits still   |
// |            owed for the current packet and an integer credit count.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_flit_serializer_3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flit_serializer_3_if #(.WIDTH_IN(36), .BUFFER_DEPTH(8)) bus0 ();
   flit_serializer_3_if #(.WIDTH_IN(36), .BUFFER_DEPTH(2)) bus1 ();

   flit_serializer_3 #(.WIDTH_IN(36), .VC_ADDRESS_WIDTH(1), .BUFFER_DEPTH(8)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   flit_serializer_3 #(.WIDTH_IN(36), .VC_ADDRESS_WIDTH(1), .BUFFER_DEPTH(2)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [11:0] pend [2][$];
   int          cred [2];
   int          depth [2] = '{8, 2};
   bit          acc [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Flits a word owes: valid flits in order, stopping after a tail.
   task automatic load_packet(input int d, input logic [35:0] w);
      logic [11:0] f;
      for (int k = 0; k < 3; k++) begin
         f = w[35-12*k -: 12];
         if (f[11]) begin
            pend[d].push_back(f);
            if (f[9]) break;
         end
      end
   endtask

   // Inputs are set just after a posedge; compare outputs, advance the
   // model across the next edge, return 1 time unit after it.
   task automatic tick();
      logic        vo, ro, vin, cin;
      logic [3:0]  cr;
      logic [11:0] fo;
      logic [35:0] din;
      bit          ev, er;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            vo = bus0.valid_out; ro = bus0.ready_out; cr = bus0.credits;
            fo = bus0.flit_out;  vin = bus0.valid_in; din = bus0.data_in;
            cin = bus0.credit_in;
         end else begin
            vo = bus1.valid_out; ro = bus1.ready_out; cr = {2'b00, bus1.credits};
            fo = bus1.flit_out;  vin = bus1.valid_in; din = bus1.data_in;
            cin = bus1.credit_in;
         end
         ev = !rst && (pend[d].size() > 0) && (cred[d] > 0);
         er = !rst && ((pend[d].size() == 0) || (ev && (pend[d].size() == 1)));
         check($sformatf("d%0d_valid_out", d), 64'(vo), 64'(ev));
         check($sformatf("d%0d_ready_out", d), 64'(ro), 64'(er));
         check($sformatf("d%0d_credits", d), 64'(cr), 64'(cred[d]));
         if (ev) check($sformatf("d%0d_flit_out", d), 64'(fo), 64'(pend[d][0]));
         acc[d] = 1'b0;
         if (rst) begin
            pend[d].delete();
            cred[d] = depth[d];
         end else begin
            if (ev) begin
               void'(pend[d].pop_front());
               cred[d]--;
            end
            if (cin && (cred[d] < depth[d])) cred[d]++;
            if (vin && er) begin
               acc[d] = 1'b1;
               load_packet(d, din);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic refill(input int d);
      while (cred[d] < depth[d]) begin
         if (d == 0) bus0.credit_in = 1'b1; else bus1.credit_in = 1'b1;
         tick();
      end
      bus0.credit_in = 1'b0;
      bus1.credit_in = 1'b0;
   endtask

   initial begin
      int          n;
      logic [63:0] r64;

      rst = 1'b1;
      bus0.valid_in = 1'b0; bus0.data_in = '0; bus0.credit_in = 1'b0;
      bus1.valid_in = 1'b0; bus1.data_in = '0; bus1.credit_in = 1'b0;
      cred[0] = 8; cred[1] = 2;
      @(posedge clk);
      #1;
      // Reset state.
      check("rst_flit0", 64'(bus0.flit_out), 64'h0);
      check("rst_valid0", 64'(bus0.valid_out), 64'h0);
      check("rst_ready0", 64'(bus0.ready_out), 64'h0);
      check("rst_credits0", 64'(bus0.credits), 64'd8);
      check("rst_credits1", 64'(bus1.credits), 64'd2);
      tick();
      tick();
      rst = 1'b0;

      // Single-flit packet.
      bus0.valid_in = 1'b1; bus0.data_in = 36'hE5A200200;
      tick();
      check("single_accept", 64'(acc[0]), 64'h1);
      bus0.valid_in = 1'b0;
      repeat (3) tick();
      check("single_credits", 64'(bus0.credits), 64'd7);
      refill(0);

      // 3-flit packet.
      bus0.valid_in = 1'b1; bus0.data_in = 36'hC5A8ABACD;
      tick();
      bus0.valid_in = 1'b0;
      repeat (4) tick();
      check("three_credits", 64'(bus0.credits), 64'd5);
      refill(0);

      // Back-to-back words with valid_in held high.
      bus0.valid_in = 1'b1; bus0.data_in = 36'hC5A8ABACD;
      tick();
      check("b2b_first_accept", 64'(acc[0]), 64'h1);
      bus0.data_in = 36'hC1189AAE7;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc[0] && (n < 10));
      check("b2b_second_accept_cycle", 64'(n), 64'd3);
      bus0.valid_in = 1'b0;
      repeat (4) tick();
      check("b2b_credits", 64'(bus0.credits), 64'd2);
      refill(0);

      // Credit return in the same cycle as a transfer.
      bus0.valid_in = 1'b1; bus0.data_in = 36'hC5A8ABACD;
      tick();
      bus0.valid_in = 1'b0;
      tick();
      bus0.credit_in = 1'b1;
      tick();
      bus0.credit_in = 1'b0;
      tick();
      check("simul_credits", 64'(bus0.credits), 64'd6);
      refill(0);

      // Reset right after flit 1.
      bus0.valid_in = 1'b1; bus0.data_in = 36'hC5A8ABACD;
      tick();
      bus0.valid_in = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("postrst_ready", 64'(bus0.ready_out), 64'h1);
      check("postrst_credits", 64'(bus0.credits), 64'd8);
      check("postrst_valid", 64'(bus0.valid_out), 64'h0);
      repeat (3) tick();

      // Credit starvation on the depth-2 instance.
      bus1.valid_in = 1'b1; bus1.data_in = 36'hC5A8ABACD;
      tick();
      bus1.valid_in = 1'b0;
      repeat (4) tick();
      bus1.credit_in = 1'b1;
      tick();
      bus1.credit_in = 1'b0;
      tick();
      check("starve_credits", 64'(bus1.credits), 64'd0);
      tick();
      refill(1);

      // Random traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         r64 = {$urandom, $urandom};
         bus0.data_in   = r64[35:0];
         bus0.valid_in  = 1'($urandom_range(0, 1));
         bus0.credit_in = ($urandom_range(0, 2) == 0) && (cred[0] < depth[0]);
         r64 = {$urandom, $urandom};
         bus1.data_in   = r64[35:0];
         bus1.valid_in  = 1'($urandom_range(0, 1));
         bus1.credit_in = ($urandom_range(0, 1) == 0) && (cred[1] < depth[1]);
         tick();
      end
      rst = 1'b0;
      bus0.valid_in = 1'b0; bus0.credit_in = 1'b0;
      bus1.valid_in = 1'b0; bus1.credit_in = 1'b0;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
